// File: rtl/mem_stage.sv
// Memory stage of the 5-stage pipeline: EX/MEM and MEM/WB registers, plus a
// request/ready handshake to data memory with misalignment and timeout faults.
module mem_stage #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flushM,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MemWriteE,
  input  logic [3:0]       RdE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             stallM,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [3:0]       RdM,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic [3:0]       RdW,
  output logic [WIDTH-1:0] ALUOutW,
  output logic [WIDTH-1:0] ReadDataW,
  output logic             mem_fault
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_t           state, nextState;
  logic [7:0]       waitCnt, nextCnt;
  logic             memtoRegM, memWriteM;
  logic [WIDTH-1:0] writeDataM;
  logic             memOp, misaligned, abortAcc, misFault;

  // EX/MEM register; a flush only zeroes the control bits, data rides along
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteM  <= 1'b0;
      memtoRegM  <= 1'b0;
      memWriteM  <= 1'b0;
      RdM        <= '0;
      ALUResultM <= '0;
      writeDataM <= '0;
    end else if (!stallM) begin
      RegWriteM  <= RegWriteE & ~flushM;
      memtoRegM  <= MemtoRegE & ~flushM;
      memWriteM  <= MemWriteE & ~flushM;
      RdM        <= RdE;
      ALUResultM <= ALUResultE;
      writeDataM <= WriteDataE;
    end
  end

  assign memOp      = memtoRegM | memWriteM;
  assign misaligned = (ALUResultM[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextCnt;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = waitCnt;
    case (state)
      IDLE: begin
        if (mem_req && !mem_ready) begin
          nextState = ACCESS;
          nextCnt   = 8'd1;
        end
      end
      ACCESS: begin
        if (mem_ready || abortAcc) begin
          nextState = IDLE;
          nextCnt   = '0;
        end else begin
          nextCnt = waitCnt + 8'd1;
        end
      end
    endcase
  end

  // Address and data need no extra capture: the stall freezes EX/MEM
  always_comb begin
    mem_req  = 1'b0;
    abortAcc = 1'b0;
    misFault = 1'b0;
    case (state)
      IDLE: begin
        mem_req  = memOp & ~misaligned;
        misFault = memOp & misaligned;
      end
      ACCESS: begin
        mem_req  = 1'b1;
        abortAcc = (waitCnt == MaxWait) & ~mem_ready;
      end
    endcase
  end

  assign mem_fault = abortAcc | misFault;
  assign stallM    = mem_req & ~mem_ready & ~abortAcc;
  assign mem_we    = memWriteM;
  assign mem_addr  = ALUResultM;
  assign mem_wdata = writeDataM;

  // MEM/WB register; a faulted instruction retires without writing back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      RdW       <= '0;
      ALUOutW   <= '0;
      ReadDataW <= '0;
    end else if (stallM) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM & ~mem_fault;
      MemtoRegW <= memtoRegM;
      RdW       <= RdM;
      ALUOutW   <= ALUResultM;
      if (memtoRegM && mem_req && mem_ready) ReadDataW <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one table row per clock cycle, followed by a
// hand-written asynchronous-reset-during-access sequence.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flushM, RegWriteE, MemtoRegE, MemWriteE;
  logic [3:0]  RdE;
  logic [31:0] ALUResultE, WriteDataE;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, stallM, RegWriteM, RegWriteW, MemtoRegW, mem_fault;
  logic [31:0] mem_addr, mem_wdata, ALUResultM, ALUOutW, ReadDataW;
  logic [3:0]  RdM, RdW;

  int testsRun  = 0;
  int failCount = 0;

  mem_stage #(.WIDTH(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .flushM(flushM),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .RdE(RdE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stallM(stallM), .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .RdW(RdW),
    .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  // Inputs for the cycle, then what the outputs must show in that same cycle
  typedef struct {
    logic        flush, rw, m2r, mw;
    logic [3:0]  rd;
    logic [31:0] alu, wd;
    logic        rdy;
    logic [31:0] rdata;
    logic        eReq, eWe;
    logic [31:0] eAddr, eWdata;
    logic        eStall, eFault, eRwM, eRwW, eM2rW;
    logic [3:0]  eRdW;
    logic        chkW;
    logic [31:0] eAluW, eRdataW;
  } vector_t;

  vector_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vector_t v);
    flushM     = v.flush;
    RegWriteE  = v.rw;
    MemtoRegE  = v.m2r;
    MemWriteE  = v.mw;
    RdE        = v.rd;
    ALUResultE = v.alu;
    WriteDataE = v.wd;
    mem_ready  = v.rdy;
    mem_rdata  = v.rdata;
  endtask

  task automatic checkRow(input int i, input vector_t v);
    checkOutput($sformatf("c%0d mem_req", i), 32'(mem_req), 32'(v.eReq));
    checkOutput($sformatf("c%0d stallM", i), 32'(stallM), 32'(v.eStall));
    checkOutput($sformatf("c%0d mem_fault", i), 32'(mem_fault), 32'(v.eFault));
    checkOutput($sformatf("c%0d RegWriteM", i), 32'(RegWriteM), 32'(v.eRwM));
    checkOutput($sformatf("c%0d RegWriteW", i), 32'(RegWriteW), 32'(v.eRwW));
    checkOutput($sformatf("c%0d MemtoRegW", i), 32'(MemtoRegW), 32'(v.eM2rW));
    if (v.eReq) begin
      checkOutput($sformatf("c%0d mem_we", i), 32'(mem_we), 32'(v.eWe));
      checkOutput($sformatf("c%0d mem_addr", i), mem_addr, v.eAddr);
      if (v.eWe) checkOutput($sformatf("c%0d mem_wdata", i), mem_wdata, v.eWdata);
    end
    if (v.chkW) begin
      checkOutput($sformatf("c%0d RdW", i), 32'(RdW), 32'(v.eRdW));
      checkOutput($sformatf("c%0d ALUOutW", i), ALUOutW, v.eAluW);
      checkOutput($sformatf("c%0d ReadDataW", i), ReadDataW, v.eRdataW);
    end
  endtask

  task automatic nopInputs();
    vector_t v;
    v = '{'0, '0, '0, '0, 4'd0, 32'h0, 32'h0, '0, 32'h0,
          '0, '0, 32'h0, 32'h0, '0, '0, '0, '0, '0, 4'd0, '0, 32'h0, 32'h0};
    applyStimulus(v);
  endtask

  initial begin
    reset = 1'b0;
    nopInputs();

    // c0-c2 single-cycle load; c3-c6 store stalled 3 cycles; c7-c9 misaligned load
    vecs.push_back('{'0,'1,'1,'0,4'd3,32'h10,32'h0, '0,32'h0, '0,'0,32'h0,32'h0, '0,'0, '0,'0,'0,4'd0, '1,32'h0,32'h0});
    vecs.push_back('{'0,'0,'0,'0,4'd0,32'h0,32'h0, '1,32'hDEADBEEF, '1,'0,32'h10,32'h0, '0,'0, '1,'0,'0,4'd0, '1,32'h0,32'h0});
    vecs.push_back('{'0,'0,'0,'1,4'd5,32'h20,32'h12345678, '0,32'h0, '0,'0,32'h0,32'h0, '0,'0, '0,'1,'1,4'd3, '1,32'h10,32'hDEADBEEF});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{'0,'1,'0,'0,4'd7,32'h99,32'h0, '0,32'h0, '1,'1,32'h20,32'h12345678, '1,'0, '0,'0,'0,4'd0, '0,32'h0,32'h0});
    vecs.push_back('{'0,'1,'0,'0,4'd7,32'h99,32'h0, '1,32'h0, '1,'1,32'h20,32'h12345678, '0,'0, '0,'0,'0,4'd0, '0,32'h0,32'h0});
    vecs.push_back('{'0,'1,'1,'0,4'd4,32'h22,32'h0, '0,32'h0, '0,'0,32'h0,32'h0, '0,'0, '1,'0,'0,4'd5, '0,32'h0,32'h0});
    vecs.push_back('{'0,'0,'0,'0,4'd0,32'h0,32'h0, '1,32'h00000BAD, '0,'0,32'h0,32'h0, '0,'1, '1,'1,'0,4'd7, '1,32'h99,32'hDEADBEEF});
    // c9-c15 load at 0x40 that never gets mem_ready: 4 stall cycles, abort on the 5th
    vecs.push_back('{'0,'1,'1,'0,4'd6,32'h40,32'h0, '0,32'h0, '0,'0,32'h0,32'h0, '0,'0, '0,'0,'1,4'd4, '1,32'h22,32'hDEADBEEF});
    for (int k = 0; k < 4; k++)
      vecs.push_back('{'0,'1,'0,'0,4'd8,32'h5,32'h0, '0,32'h0, '1,'0,32'h40,32'h0, '1,'0, '1,'0,'0,4'd0, '0,32'h0,32'h0});
    vecs.push_back('{'0,'1,'0,'0,4'd8,32'h5,32'h0, '0,32'h0, '1,'0,32'h40,32'h0, '0,'1, '1,'0,'0,4'd0, '0,32'h0,32'h0});
    vecs.push_back('{'0,'0,'0,'0,4'd0,32'h0,32'h0, '0,32'h0, '0,'0,32'h0,32'h0, '0,'0, '1,'0,'1,4'd6, '1,32'h40,32'hDEADBEEF});
    // c16-c21 flush of an ADD, then flush during a stalled load (ignored)
    vecs.push_back('{'1,'1,'0,'0,4'd9,32'h77,32'h0, '0,32'h0, '0,'0,32'h0,32'h0, '0,'0, '0,'1,'0,4'd8, '1,32'h5,32'hDEADBEEF});
    vecs.push_back('{'0,'0,'0,'0,4'd0,32'h0,32'h0, '0,32'h0, '0,'0,32'h0,32'h0, '0,'0, '0,'0,'0,4'd0, '0,32'h0,32'h0});
    vecs.push_back('{'0,'1,'1,'0,4'd10,32'h80,32'h0, '0,32'h0, '0,'0,32'h0,32'h0, '0,'0, '0,'0,'0,4'd0, '0,32'h0,32'h0});
    vecs.push_back('{'1,'0,'0,'0,4'd0,32'h0,32'h0, '0,32'h0, '1,'0,32'h80,32'h0, '1,'0, '1,'0,'0,4'd0, '0,32'h0,32'h0});
    vecs.push_back('{'1,'1,'0,'0,4'd11,32'h33,32'h0, '1,32'hCAFEF00D, '1,'0,32'h80,32'h0, '0,'0, '1,'0,'0,4'd0, '0,32'h0,32'h0});
    vecs.push_back('{'0,'0,'0,'0,4'd0,32'h0,32'h0, '0,32'h0, '0,'0,32'h0,32'h0, '0,'0, '0,'1,'1,4'd10, '1,32'h80,32'hCAFEF00D});

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset mem_req", 32'(mem_req), 32'h0);
    checkOutput("reset RegWriteW", 32'(RegWriteW), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkRow(i, vecs[i]);
    end

    // Reset asserted while a load is waiting in ACCESS
    @(negedge clk);
    nopInputs();
    RegWriteE = 1'b1; MemtoRegE = 1'b1; RdE = 4'd12; ALUResultE = 32'h100;
    @(negedge clk);
    nopInputs();
    #1;
    checkOutput("rst pre req", 32'(mem_req), 32'h1);
    @(negedge clk);
    #1;
    checkOutput("rst pre stall", 32'(stallM), 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("rst mem_req", 32'(mem_req), 32'h0);
    checkOutput("rst stallM", 32'(stallM), 32'h0);
    checkOutput("rst RegWriteM", 32'(RegWriteM), 32'h0);
    checkOutput("rst RegWriteW", 32'(RegWriteW), 32'h0);
    checkOutput("rst MemtoRegW", 32'(MemtoRegW), 32'h0);
    checkOutput("rst RdW", 32'(RdW), 32'h0);
    checkOutput("rst ALUOutW", ALUOutW, 32'h0);
    checkOutput("rst ReadDataW", ReadDataW, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    RegWriteE = 1'b1; MemtoRegE = 1'b1; RdE = 4'd13; ALUResultE = 32'h104;
    @(negedge clk);
    nopInputs();
    mem_ready = 1'b1; mem_rdata = 32'h0BADCAFE;
    #1;
    checkOutput("post req", 32'(mem_req), 32'h1);
    checkOutput("post stall", 32'(stallM), 32'h0);
    checkOutput("post addr", mem_addr, 32'h104);
    @(negedge clk);
    nopInputs();
    #1;
    checkOutput("post RegWriteW", 32'(RegWriteW), 32'h1);
    checkOutput("post MemtoRegW", 32'(MemtoRegW), 32'h1);
    checkOutput("post RdW", 32'(RdW), 32'd13);
    checkOutput("post ReadDataW", ReadDataW, 32'h0BADCAFE);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
